// File: rtl/commit_trace_buffer.sv
// Retire-side trace capture: classifies commits, stamps INUMs, buffers them in a FIFO
// and sequences halt -> drain -> done.
module commit_trace_buffer #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 32,
    parameter int FILTER_NOP = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         commit_valid,
    input  logic [DATA_W-1:0]            commit_pc,
    input  logic [DATA_W-1:0]            commit_inst,
    input  logic                         commit_regwrite,
    input  logic [REG_AW-1:0]            commit_wreg,
    input  logic [DATA_W-1:0]            commit_wdata,
    input  logic                         commit_memread,
    input  logic                         commit_memwrite,
    input  logic [DATA_W-1:0]            commit_memaddr,
    input  logic [DATA_W-1:0]            commit_memdata,
    input  logic                         commit_halt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_kind,
    output logic [CNT_W-1:0]             out_inum,
    output logic [DATA_W-1:0]            out_pc,
    output logic [DATA_W-1:0]            out_inst,
    output logic [REG_AW-1:0]            out_reg,
    output logic [DATA_W-1:0]            out_regdata,
    output logic [DATA_W-1:0]            out_addr,
    output logic [DATA_W-1:0]            out_memdata,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             inst_count,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow,
    output logic                         halted,
    output logic                         done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW1   = PTR_W + 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [2:0] K_REG  = 3'd0;
    localparam logic [2:0] K_LD   = 3'd1;
    localparam logic [2:0] K_ST   = 3'd2;
    localparam logic [2:0] K_STU  = 3'd3;
    localparam logic [2:0] K_NOP  = 3'd4;
    localparam logic [2:0] K_HALT = 3'd5;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] regdata;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] memdata;
    } rec_t;

    state_e           state_q, state_d;
    logic [PTR_W:0]   wr_q, wr_d;
    logic [PTR_W:0]   rd_q, rd_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] inst_q, inst_d;
    logic             ovf_q, ovf_d;

    rec_t             fifo_mem [DEPTH];
    rec_t             rec_in;
    rec_t             head;
    logic [2:0]       kind;
    logic [OCC_W-1:0] occ;
    logic             accept, keep, full, empty, pop, push, drop;

    always_comb begin
        kind = K_NOP;
        if (commit_halt)                            kind = K_HALT;
        else if (commit_regwrite && commit_memwrite) kind = K_STU;
        else if (commit_regwrite && commit_memread)  kind = K_LD;
        else if (commit_regwrite)                    kind = K_REG;
        else if (commit_memwrite)                    kind = K_ST;
    end

    always_comb begin
        rec_in         = '0;
        rec_in.kind    = kind;
        rec_in.inum    = inst_q;
        rec_in.pc      = commit_pc;
        rec_in.inst    = commit_inst;
        rec_in.rd      = commit_wreg;
        rec_in.regdata = commit_wdata;
        rec_in.addr    = commit_memaddr;
        rec_in.memdata = commit_memdata;
    end

    always_comb begin
        occ    = OCC_W'(wr_q - rd_q);
        empty  = (occ == '0);
        full   = (occ == OCC_W'(DEPTH));
        accept = commit_valid && (state_q == S_RUN);
        keep   = (FILTER_NOP == 0) || (kind != K_NOP);
        pop    = !empty && out_ready;
        // A full FIFO still takes a record when the head leaves on the same edge.
        push   = accept && keep && (!full || pop);
        drop   = accept && keep && full && !pop;

        wr_d   = wr_q + PW1'(push);
        rd_d   = rd_q + PW1'(pop);
        inst_d = inst_q + CNT_W'(accept);
        cyc_d  = (state_q != S_DONE) ? cyc_q + 1'b1 : cyc_q;
        ovf_d  = ovf_q | drop;

        state_d = state_q;
        case (state_q)
            S_RUN:   if (accept && commit_halt) state_d = S_DRAIN;
            S_DRAIN: if (empty) state_d = S_DONE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            wr_q    <= '0;
            rd_q    <= '0;
            cyc_q   <= '0;
            inst_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_q[PTR_W-1:0]] <= rec_in;
    end

    // Record fields read as zero whenever nothing is queued.
    always_comb begin
        head = '0;
        if (!empty) head = fifo_mem[rd_q[PTR_W-1:0]];
    end

    assign out_valid   = !empty;
    assign out_kind    = head.kind;
    assign out_inum    = head.inum;
    assign out_pc      = head.pc;
    assign out_inst    = head.inst;
    assign out_reg     = head.rd;
    assign out_regdata = head.regdata;
    assign out_addr    = head.addr;
    assign out_memdata = head.memdata;

    assign cycle_count = cyc_q;
    assign inst_count  = inst_q;
    assign occupancy   = occ;
    assign overflow    = ovf_q;
    assign halted      = (state_q != S_RUN);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios plus random traffic, checked
// against a queue-based reference model for an unfiltered and a NOP-filtering instance.
module tb_commit_trace_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [15:0] commit_pc = '0, commit_inst = '0, commit_wdata = '0;
    logic [15:0] commit_memaddr = '0, commit_memdata = '0;
    logic [2:0]  commit_wreg = '0;
    logic        commit_regwrite = 1'b0, commit_memread = 1'b0;
    logic        commit_memwrite = 1'b0, commit_halt = 1'b0;
    logic        out_ready = 1'b0;

    logic        ov   [2];
    logic [2:0]  okd  [2];
    logic [31:0] oin  [2];
    logic [15:0] opc  [2], oins [2], ordt [2], oadr [2], omd [2];
    logic [2:0]  org  [2];
    logic [31:0] ocyc [2], oicn [2];
    logic [3:0]  oocc [2];
    logic        oovf [2], ohlt [2], odne [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .FILTER_NOP(0)) u_dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_regwrite(commit_regwrite), .commit_wreg(commit_wreg),
        .commit_wdata(commit_wdata), .commit_memread(commit_memread),
        .commit_memwrite(commit_memwrite), .commit_memaddr(commit_memaddr),
        .commit_memdata(commit_memdata), .commit_halt(commit_halt),
        .out_valid(ov[0]), .out_ready(out_ready), .out_kind(okd[0]),
        .out_inum(oin[0]), .out_pc(opc[0]), .out_inst(oins[0]),
        .out_reg(org[0]), .out_regdata(ordt[0]), .out_addr(oadr[0]),
        .out_memdata(omd[0]), .cycle_count(ocyc[0]), .inst_count(oicn[0]),
        .occupancy(oocc[0]), .overflow(oovf[0]), .halted(ohlt[0]), .done(odne[0])
    );

    commit_trace_buffer #(.DEPTH(DEPTH), .FILTER_NOP(1)) u_flt (
        .clk(clk), .rst(rst), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_regwrite(commit_regwrite), .commit_wreg(commit_wreg),
        .commit_wdata(commit_wdata), .commit_memread(commit_memread),
        .commit_memwrite(commit_memwrite), .commit_memaddr(commit_memaddr),
        .commit_memdata(commit_memdata), .commit_halt(commit_halt),
        .out_valid(ov[1]), .out_ready(out_ready), .out_kind(okd[1]),
        .out_inum(oin[1]), .out_pc(opc[1]), .out_inst(oins[1]),
        .out_reg(org[1]), .out_regdata(ordt[1]), .out_addr(oadr[1]),
        .out_memdata(omd[1]), .cycle_count(ocyc[1]), .inst_count(oicn[1]),
        .occupancy(oocc[1]), .overflow(oovf[1]), .halted(ohlt[1]), .done(odne[1])
    );

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc, inst, regdata, addr, memdata;
        logic [2:0]  rd;
    } rec_t;

    rec_t        mq [2][$];
    logic [31:0] m_cyc [2];
    logic [31:0] m_inst [2];
    bit          m_ovf [2], m_halted [2], m_done [2];

    function automatic logic [2:0] kind_of(input logic h, rw, mr, mw);
        if (h)             return 3'd5;
        else if (rw && mw) return 3'd3;
        else if (rw && mr) return 3'd1;
        else if (rw)       return 3'd0;
        else if (mw)       return 3'd2;
        return 3'd4;
    endfunction

    always @(posedge clk) begin : model
        bit   was_empty;
        rec_t r;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                m_cyc[i] = 0; m_inst[i] = 0;
                m_ovf[i] = 0; m_halted[i] = 0; m_done[i] = 0;
            end else begin
                was_empty = (mq[i].size() == 0);
                if (!m_done[i]) m_cyc[i] = m_cyc[i] + 1;
                if (m_halted[i] && was_empty) m_done[i] = 1;
                if (!was_empty && out_ready) void'(mq[i].pop_front());
                if (commit_valid && !m_halted[i]) begin
                    r.kind = kind_of(commit_halt, commit_regwrite,
                                     commit_memread, commit_memwrite);
                    r.inum = m_inst[i];
                    r.pc = commit_pc; r.inst = commit_inst;
                    r.rd = commit_wreg; r.regdata = commit_wdata;
                    r.addr = commit_memaddr; r.memdata = commit_memdata;
                    if (!(i == 1 && r.kind == 3'd4)) begin
                        if (mq[i].size() < DEPTH) mq[i].push_back(r);
                        else m_ovf[i] = 1;
                    end
                    m_inst[i] = m_inst[i] + 1;
                    if (commit_halt) m_halted[i] = 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        rec_t h;
        for (int i = 0; i < 2; i++) begin
            h = '{kind: 3'd0, inum: 32'd0, pc: 16'd0, inst: 16'd0,
                  regdata: 16'd0, addr: 16'd0, memdata: 16'd0, rd: 3'd0};
            if (mq[i].size() > 0) h = mq[i][0];
            chk($sformatf("valid%0d", i), ov[i], mq[i].size() > 0);
            chk($sformatf("kind%0d", i), okd[i], h.kind);
            chk($sformatf("inum%0d", i), oin[i], h.inum);
            chk($sformatf("pc%0d", i), opc[i], h.pc);
            chk($sformatf("inst%0d", i), oins[i], h.inst);
            chk($sformatf("reg%0d", i), org[i], h.rd);
            chk($sformatf("regdata%0d", i), ordt[i], h.regdata);
            chk($sformatf("addr%0d", i), oadr[i], h.addr);
            chk($sformatf("memdata%0d", i), omd[i], h.memdata);
            chk($sformatf("occ%0d", i), oocc[i], mq[i].size());
            chk($sformatf("cycles%0d", i), ocyc[i], m_cyc[i]);
            chk($sformatf("icount%0d", i), oicn[i], m_inst[i]);
            chk($sformatf("ovf%0d", i), oovf[i], m_ovf[i]);
            chk($sformatf("halted%0d", i), ohlt[i], m_halted[i]);
            chk($sformatf("done%0d", i), odne[i], m_done[i]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        commit_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        commit_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic commit(input logic h, rw, mr, mw,
                          input logic [15:0] pc, input logic [2:0] rd,
                          input logic [15:0] wd, ad, md);
        commit_valid = 1'b1;
        commit_halt = h; commit_regwrite = rw;
        commit_memread = mr; commit_memwrite = mw;
        commit_pc = pc; commit_inst = pc ^ 16'h5A5A;
        commit_wreg = rd; commit_wdata = wd;
        commit_memaddr = ad; commit_memdata = md;
        tick();
        commit_valid = 1'b0;
        commit_halt = 1'b0;
    endtask

    task automatic rand_commit(input int halt_pct);
        commit(($urandom_range(99) < halt_pct), 1'($urandom), 1'($urandom),
               1'($urandom), 16'($urandom), 3'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom));
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!(m_done[0] && m_done[1]) && n < limit) begin
            tick();
            n++;
        end
        chk("done_timeout", (m_done[0] && m_done[1]), 1);
    endtask

    initial begin
        // Reset values and basic record types
        do_reset(2);
        chk("rst_icount", oicn[0], 0);
        chk("rst_valid", ov[0], 0);
        out_ready = 1'b1;
        commit(0, 1, 0, 0, 16'h0000, 3'd3, 16'h1234, 16'h0, 16'h0);
        chk("t1_kind_reg", okd[0], 0);
        chk("t1_inum0", oin[0], 0);
        chk("t1_regdata", ordt[0], 16'h1234);
        commit(0, 1, 1, 0, 16'h0002, 3'd1, 16'h0077, 16'h0040, 16'h0);
        chk("t1_kind_ld", okd[0], 1);
        chk("t1_addr_ld", oadr[0], 16'h0040);
        commit(0, 0, 0, 1, 16'h0004, 3'd0, 16'h0, 16'h0042, 16'hBEEF);
        chk("t1_kind_st", okd[0], 2);
        chk("t1_inum2", oin[0], 2);
        chk("t1_memdata", omd[0], 16'hBEEF);
        idle(2);
        chk("t1_icount", oicn[0], 3);

        // STU then NOP; the filtered instance drops the NOP record
        do_reset(2);
        commit(0, 1, 0, 1, 16'h0010, 3'd2, 16'h1111, 16'h0020, 16'h2222);
        chk("t2_kind_stu", okd[0], 3);
        chk("t2_flt_stu", okd[1], 3);
        commit(0, 0, 0, 0, 16'h0012, 3'd0, 16'h0, 16'h0, 16'h0);
        chk("t2_kind_nop", okd[0], 4);
        chk("t2_flt_empty", ov[1], 0);
        chk("t2_flt_icount", oicn[1], 2);
        idle(2);

        // Overflow with a stalled consumer
        do_reset(1);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++)
            commit(0, 1, 0, 0, 16'(k * 2), 3'(k), 16'(k), 16'h0, 16'h0);
        chk("t3_occ", oocc[0], 8);
        chk("t3_ovf", oovf[0], 1);
        chk("t3_icount", oicn[0], 10);
        chk("t3_head_inum", oin[0], 0);
        out_ready = 1'b1;
        idle(10);

        // Full FIFO, simultaneous pop and push
        do_reset(1);
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++)
            commit(0, 0, 0, 1, 16'(k), 3'd0, 16'h0, 16'(k), 16'(k));
        out_ready = 1'b1;
        commit(0, 0, 0, 1, 16'h0100, 3'd0, 16'h0, 16'h0100, 16'h0100);
        chk("t4_occ", oocc[0], 8);
        chk("t4_ovf", oovf[0], 0);
        idle(10);

        // HALT with queued entries, toggling ready, ignored extras
        do_reset(1);
        for (int k = 0; k < 12; k++) begin
            out_ready = 1'($urandom);
            rand_commit(0);
        end
        out_ready = 1'b0;
        idle(8);
        for (int k = 0; k < 3; k++) rand_commit(0);
        commit(1, 0, 0, 0, 16'h00FE, 3'd0, 16'h0, 16'h0, 16'h0);
        chk("t5_halted", ohlt[0], 1);
        chk("t5_done0", odne[0], 0);
        for (int k = 0; k < 6; k++) begin
            out_ready = ~out_ready;
            rand_commit(0);
        end
        out_ready = 1'b1;
        wait_done(40);
        chk("t5_empty", oocc[0], 0);
        idle(5);

        // Reset in the middle of a drain
        do_reset(1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) rand_commit(0);
        commit(1, 0, 0, 0, 16'h0040, 3'd0, 16'h0, 16'h0, 16'h0);
        chk("t6_occ4", oocc[0], 4);
        do_reset(1);
        chk("t6_occ0", oocc[0], 0);
        chk("t6_halted0", ohlt[0], 0);
        chk("t6_cycles0", ocyc[0], 0);
        out_ready = 1'b1;
        commit(0, 1, 0, 0, 16'h0050, 3'd4, 16'h4444, 16'h0, 16'h0);
        chk("t6_inum0", oin[0], 0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            out_ready = ($urandom_range(3) != 0);
            if ((m_done[0] && m_done[1]) || $urandom_range(199) == 0) begin
                do_reset(1);
            end else if ($urandom_range(2) != 0) begin
                rand_commit(3);
            end else begin
                idle(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
